// File: rtl/sonar_pkg.sv
// Shared types and timing defaults for the ultrasonic ranging front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  // Defaults assume a 100 MHz clock
  localparam int TRIG_CYCLES_DEF      = 1000;     // 10 us trigger
  localparam int CYC_PER_INCH_DEF     = 14800;    // 148 us round trip per inch
  localparam int ECHO_WAIT_CYCLES_DEF = 3000000;  // 30 ms echo window
  localparam int HOLDOFF_CYCLES_DEF   = 6000000;  // 60 ms re-arm dead time

  localparam logic [7:0] INCH_MAX = 8'd255;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Two-flop synchronizer for an asynchronous level, plus edge detection.
// Latency: rise/fall pulse visible 2 clk after the raw edge is sampled.
// Backpressure: none; pulses are single-cycle and derived from flops only.
module sonar_echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Metastability filter followed by a one-cycle history flop for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  // Both edges see the same delay, so pulse spacing equals raw pulse width
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/sonar_ranger.sv
// Fires one trigger per start, times the echo and reports whole inches.
// Latency: valid 3 clk after raw echo fall; ready returns HOLDOFF_CYCLES+1 clk after valid.
// Backpressure: start only accepted while ready=1; starts while busy are dropped.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES      = TRIG_CYCLES_DEF,
  parameter int CYC_PER_INCH     = CYC_PER_INCH_DEF,
  parameter int ECHO_WAIT_CYCLES = ECHO_WAIT_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES   = HOLDOFF_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sonar_echo,
  output logic       sonar_trigger,
  output logic [7:0] inches,
  output logic       timeout,
  output logic       valid,
  output logic       ready
);

  localparam int TW = cnt_width(TRIG_CYCLES);
  localparam int PW = cnt_width(CYC_PER_INCH);
  localparam int WW = cnt_width(ECHO_WAIT_CYCLES);
  localparam int HW = cnt_width(HOLDOFF_CYCLES);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CYC_PER_INCH - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ECHO_WAIT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] trig_cnt;
  logic [PW-1:0] presc;
  logic [WW-1:0] wait_cnt;
  logic [HW-1:0] hold_cnt;
  logic [7:0]    inch_cnt;
  logic          echo_rise;
  logic          echo_fall;
  logic          presc_wrap;

  sonar_echo_sync u_echo_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sonar_echo),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  // The cycle that carries the fall still counts toward the width
  assign presc_wrap = (presc == PRE_LAST);

  // Sequencer: trigger, echo window, width timing, result strobe, re-arm holdoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sonar_trigger <= 1'b0;
      inches        <= '0;
      timeout       <= 1'b0;
      valid         <= 1'b0;
      ready         <= 1'b1;
      trig_cnt      <= '0;
      presc         <= '0;
      wait_cnt      <= '0;
      hold_cnt      <= '0;
      inch_cnt      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= TRIG;
            ready         <= 1'b0;
            sonar_trigger <= 1'b1;
            trig_cnt      <= '0;
          end
        end
        TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            sonar_trigger <= 1'b0;
            wait_cnt      <= '0;
            state         <= WAIT_RISE;
          end else begin
            trig_cnt <= trig_cnt + TW'(1);
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            presc    <= '0;
            inch_cnt <= '0;
            state    <= MEASURE;
          end else if (wait_cnt == WAIT_LAST) begin
            inches  <= INCH_MAX;
            timeout <= 1'b1;
            valid   <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        MEASURE: begin
          // A 256th inch cannot be reported, so over-range wins over a coincident fall
          if (presc_wrap && (inch_cnt == INCH_MAX)) begin
            inches  <= INCH_MAX;
            timeout <= 1'b1;
            valid   <= 1'b1;
            state   <= DONE;
          end else if (echo_fall) begin
            inches  <= inch_cnt + 8'(presc_wrap);
            timeout <= 1'b0;
            valid   <= 1'b1;
            state   <= DONE;
          end else if (presc_wrap) begin
            presc    <= '0;
            inch_cnt <= inch_cnt + 8'd1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        DONE: begin
          hold_cnt <= '0;
          state    <= HOLDOFF;
        end
        HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          sonar_trigger <= 1'b0;
          ready         <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
